// File: rtl/comp_pkg.sv
// Shared definitions for the memory write-port arbiter: owner codes,
// arbiter states and default bus widths.
package comp_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 8;

   localparam logic [1:0] OWN_CPU  = 2'd0;
   localparam logic [1:0] OWN_SER  = 2'd1;
   localparam logic [1:0] OWN_MAN  = 2'd2;
   localparam logic [1:0] OWN_NONE = 2'd3;

   typedef enum logic [1:0] {
      RUN,
      HOLD,
      WRITE
   } arb_state_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry write-request holding register with a sticky drop flag.
// A capture in the same cycle as a clear is accepted rather than dropped.
module mem_req_slot #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_capture,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_overflow
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_capture && (!r_valid || i_clear)) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
         end else if (i_clear) begin
            r_valid <= 1'b0;
         end
         if (i_capture && r_valid && !i_clear)
            r_overflow <= 1'b1;
      end
   end

   assign o_valid    = r_valid;
   assign o_addr     = r_addr;
   assign o_data     = r_data;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/mem_write_arbiter.sv
// Shares the memory write port between the CPU and the serial/manual loaders,
// parking the CPU at an instruction boundary before any loader write.
module mem_write_arbiter
   import comp_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int WR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_mode,
   input  logic              cpu_boundary,
   input  logic              cpu_halted,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              ser_valid,
   input  logic [ADDR_W-1:0] ser_addr,
   input  logic [DATA_W-1:0] ser_data,
   input  logic              man_key,
   input  logic [ADDR_W-1:0] man_addr,
   input  logic [DATA_W-1:0] man_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              ser_done,
   output logic              man_done,
   output logic              ser_overflow,
   output logic [1:0]        owner
);

   localparam logic [3:0] CNT_LAST = 4'(WR_CYCLES - 1);

   arb_state_t        r_state;
   logic              r_parked, r_sel_man, r_cpu_hold, r_ser_done, r_man_done;
   logic              r_man_key_q;
   logic [1:0]        r_owner;
   logic [3:0]        r_cnt;

   logic              w_ser_pend, w_man_pend, w_any_pend, w_park_now;
   logic              w_last, w_ser_clear, w_man_clear, w_man_rise;
   logic              w_man_ovf_unused;
   logic [ADDR_W-1:0] w_ser_addr, w_man_addr;
   logic [DATA_W-1:0] w_ser_data, w_man_data;

   assign w_man_rise  = man_key & ~r_man_key_q;
   // Slots empty on the last write cycle so the done cycle already sees them free.
   assign w_last      = (r_state == WRITE) && (r_cnt == CNT_LAST);
   assign w_ser_clear = w_last & ~r_sel_man;
   assign w_man_clear = w_last & r_sel_man;
   assign w_any_pend  = w_ser_pend | w_man_pend;
   assign w_park_now  = r_parked | cpu_boundary | cpu_halted | prog_mode;

   mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ser_slot (
      .clk(clk), .rst(rst), .i_capture(ser_valid), .i_clear(w_ser_clear),
      .i_addr(ser_addr), .i_data(ser_data), .o_valid(w_ser_pend),
      .o_addr(w_ser_addr), .o_data(w_ser_data), .o_overflow(ser_overflow)
   );

   mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_man_slot (
      .clk(clk), .rst(rst), .i_capture(w_man_rise), .i_clear(w_man_clear),
      .i_addr(man_addr), .i_data(man_data), .o_valid(w_man_pend),
      .o_addr(w_man_addr), .o_data(w_man_data), .o_overflow(w_man_ovf_unused)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_parked    <= 1'b0;
         r_sel_man   <= 1'b0;
         r_cnt       <= '0;
         r_cpu_hold  <= 1'b0;
         r_ser_done  <= 1'b0;
         r_man_done  <= 1'b0;
         r_owner     <= OWN_CPU;
         r_man_key_q <= 1'b0;
      end else begin
         r_man_key_q <= man_key;
         r_ser_done  <= 1'b0;
         r_man_done  <= 1'b0;
         case (r_state)
            RUN: begin
               if (w_any_pend || prog_mode) begin
                  r_state    <= HOLD;
                  r_cpu_hold <= 1'b1;
                  r_owner    <= OWN_NONE;
               end
            end
            HOLD: begin
               if (w_park_now)
                  r_parked <= 1'b1;
               if (w_park_now && w_any_pend) begin
                  r_state   <= WRITE;
                  r_sel_man <= ~w_ser_pend;
                  r_cnt     <= '0;
                  r_owner   <= w_ser_pend ? OWN_SER : OWN_MAN;
               end else if (!w_any_pend && !prog_mode) begin
                  r_state    <= RUN;
                  r_parked   <= 1'b0;
                  r_cpu_hold <= 1'b0;
                  r_owner    <= OWN_CPU;
               end
            end
            WRITE: begin
               if (w_last) begin
                  r_state    <= HOLD;
                  r_owner    <= OWN_NONE;
                  r_ser_done <= ~r_sel_man;
                  r_man_done <= r_sel_man;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (r_state == WRITE) begin
         mem_addr  = r_sel_man ? w_man_addr : w_ser_addr;
         mem_wdata = r_sel_man ? w_man_data : w_ser_data;
      end
      if (!rst) begin
         if (r_state == RUN)
            mem_we = cpu_we;
         else if (r_state == WRITE)
            mem_we = 1'b1;
      end
   end

   assign cpu_hold = r_cpu_hold;
   assign ser_done = r_ser_done;
   assign man_done = r_man_done;
   assign owner    = r_owner;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle checked against a
// request-queue style reference model of the arbiter.
module tb_mem_write_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int W  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, prog_mode, cpu_boundary, cpu_halted, cpu_we, ser_valid, man_key;
   logic [AW-1:0] cpu_addr, ser_addr, man_addr;
   logic [DW-1:0] cpu_wdata, ser_data, man_data;
   logic          mem_we, cpu_hold, ser_done, man_done, ser_overflow;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    owner;

   mem_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .prog_mode(prog_mode), .cpu_boundary(cpu_boundary),
      .cpu_halted(cpu_halted), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .ser_valid(ser_valid), .ser_addr(ser_addr),
      .ser_data(ser_data), .man_key(man_key), .man_addr(man_addr),
      .man_data(man_data), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .ser_done(ser_done),
      .man_done(man_done), .ser_overflow(ser_overflow), .owner(owner)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: CPU-owns flag, remaining loader write cycles, two request slots.
   bit            m_on = 1'b0;
   bit            m_run, m_parked, m_wman, m_dser, m_dman, m_ovf, m_kprev, m_sf, m_mf;
   int            m_left;
   logic [AW-1:0] m_sa, m_ma;
   logic [DW-1:0] m_sd, m_md;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      bit clr_s, clr_m, nsf, nmf, rise, p;
      if (rst) begin
         m_on = 1'b1; m_run = 1'b1; m_parked = 1'b0; m_left = 0; m_wman = 1'b0;
         m_dser = 1'b0; m_dman = 1'b0; m_ovf = 1'b0; m_kprev = 1'b0;
         m_sf = 1'b0; m_mf = 1'b0;
         return;
      end
      clr_s = (m_left == 1) && !m_wman;
      clr_m = (m_left == 1) && m_wman;
      nsf = m_sf && !clr_s;
      nmf = m_mf && !clr_m;
      if (ser_valid) begin
         if (nsf) m_ovf = 1'b1;
         else begin nsf = 1'b1; m_sa = ser_addr; m_sd = ser_data; end
      end
      rise = man_key && !m_kprev;
      m_kprev = man_key;
      if (rise && !nmf) begin nmf = 1'b1; m_ma = man_addr; m_md = man_data; end
      m_dser = clr_s;
      m_dman = clr_m;
      if (m_run) begin
         if (m_sf || m_mf || prog_mode) m_run = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         p = m_parked || cpu_boundary || cpu_halted || prog_mode;
         if (p) m_parked = 1'b1;
         if (p && (m_sf || m_mf)) begin
            m_wman = !m_sf;
            m_left = W;
         end else if (!m_sf && !m_mf && !prog_mode) begin
            m_run = 1'b1;
            m_parked = 1'b0;
         end
      end
      m_sf = nsf;
      m_mf = nmf;
   endtask

   task automatic sample();
      logic       ewe;
      logic [1:0] eown;
      @(negedge clk);
      if (m_on) begin
         ewe  = !rst && (m_run ? cpu_we : (m_left > 0));
         eown = m_run ? 2'd0 : ((m_left > 0) ? (m_wman ? 2'd2 : 2'd1) : 2'd3);
         chk("model_ctl", {mem_we, cpu_hold, owner, ser_done, man_done, ser_overflow},
             {ewe, !m_run, eown, m_dser, m_dman, m_ovf});
         if (ewe)
            chk("model_bus", {mem_addr, mem_wdata},
                m_run ? {cpu_addr, cpu_wdata} : (m_wman ? {m_ma, m_md} : {m_sa, m_sd}));
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      rst = 1'b1; prog_mode = 1'b0; cpu_boundary = 1'b0; cpu_halted = 1'b0;
      cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'h55;
      ser_valid = 1'b0; ser_addr = '0; ser_data = '0;
      man_key = 1'b0; man_addr = '0; man_data = '0;

      // Reset with cpu_we high
      sample(); chk("rst_we", mem_we, 0); advance();
      sample(); chk("rst_state", {mem_we, cpu_hold, owner, ser_overflow}, 0); advance();
      rst = 1'b0;

      // Passthrough
      cpu_addr = 4'd5; cpu_wdata = 8'h2A;
      sample(); chk("pass", {mem_we, mem_addr, mem_wdata, owner}, {1'b1, 4'd5, 8'h2A, 2'd0}); advance();

      // Programming load while parked
      cpu_we = 1'b0; prog_mode = 1'b1;
      repeat (2) begin sample(); advance(); end
      for (int c = 0; c < 7; c++) begin
         ser_valid = (c == 0); ser_addr = 4'd3; ser_data = 8'h1E;
         sample();
         chk("pl_we", mem_we, (c == 2 || c == 3));
         if (c == 2 || c == 3) chk("pl_bus", {owner, mem_addr, mem_wdata}, {2'd1, 4'd3, 8'h1E});
         chk("pl_done", ser_done, (c == 4));
         chk("pl_hold", cpu_hold, 1);
         advance();
      end

      // Contention: serial and manual in the same cycle
      for (int c = 0; c < 10; c++) begin
         ser_valid = (c == 0); ser_addr = 4'hA; ser_data = 8'hC3;
         man_key = (c < 3); man_addr = 4'd6; man_data = 8'h99;
         sample();
         chk("ct_we", mem_we, (c == 2 || c == 3 || c == 5 || c == 6));
         if (c == 2 || c == 3) chk("ct_ser_bus", {owner, mem_addr, mem_wdata}, {2'd1, 4'hA, 8'hC3});
         if (c == 5 || c == 6) chk("ct_man_bus", {owner, mem_addr, mem_wdata}, {2'd2, 4'd6, 8'h99});
         chk("ct_done", {ser_done, man_done}, {(c == 4), (c == 7)});
         chk("ct_hold", cpu_hold, 1);
         advance();
      end

      prog_mode = 1'b0;
      repeat (2) begin sample(); advance(); end

      // Park wait from RUN, CPU keeps trying to write
      cpu_we = 1'b1; cpu_addr = 4'hE; cpu_wdata = 8'h77;
      for (int c = 0; c < 13; c++) begin
         ser_valid = (c == 0); ser_addr = 4'd9; ser_data = 8'h5C;
         cpu_boundary = (c >= 7);
         sample();
         chk("pw_we", mem_we, (c < 2 || c == 8 || c == 9 || c >= 11));
         chk("pw_hold", cpu_hold, (c >= 2 && c <= 10));
         chk("pw_done", ser_done, (c == 10));
         if (c == 8 || c == 9) chk("pw_ldr_bus", {owner, mem_addr, mem_wdata}, {2'd1, 4'd9, 8'h5C});
         else if (c < 2 || c >= 11) chk("pw_cpu_bus", {owner, mem_addr, mem_wdata}, {2'd0, 4'hE, 8'h77});
         advance();
      end
      cpu_we = 1'b0; cpu_boundary = 1'b0;

      // Overflow, then reset during the write
      for (int c = 0; c < 11; c++) begin
         ser_valid = (c == 0 || c == 2 || c == 4); ser_addr = 4'(c); ser_data = 8'(8'h40 + c);
         cpu_boundary = (c == 5); rst = (c == 6);
         sample();
         chk("ov_flag", ser_overflow, (c >= 3 && c <= 6));
         if (c == 6) chk("ov_rst_we", mem_we, 0);
         if (c >= 7) chk("ov_after", {mem_we, cpu_hold, owner, ser_done}, 0);
         advance();
      end
      rst = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) prog_mode = ~prog_mode;
         cpu_boundary = ($urandom_range(0, 3) == 0);
         cpu_halted   = ($urandom_range(0, 29) == 0);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = 4'($urandom);
         cpu_wdata = 8'($urandom);
         ser_valid = ($urandom_range(0, 7) == 0);
         ser_addr  = 4'($urandom);
         ser_data  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) man_key = ~man_key;
         man_addr  = 4'($urandom);
         man_data  = 8'($urandom);
         sample();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
